// File: rtl/ps2_pkg.sv
// Shared scan-code constants and frame FSM encoding for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, clock glitch filter,
// 11-bit frame FSM with odd-parity/stop checking and inter-edge timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN       = 8,
    parameter int TIMEOUT_CYCLES = 15000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    frame_state_t  state, state_next;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Any sample equal to the current filtered value restarts the run count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b0;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign strobe  = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (tmo_hit) begin
            state_next = IDLE;
            frame_err  = 1'b1;
        end else if (strobe) begin
            case (state)
                IDLE:   if (!data_s2) state_next = DATA;
                DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (data_s2 && par) byte_valid = 1'b1;
                    else                frame_err  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // par accumulates the XOR of data and parity bits; odd parity leaves it at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE || strobe) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + 1'b1;
            if (strobe) begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        par     <= 1'b0;
                    end
                    DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        par     <= par ^ data_s2;
                    end
                    PARITY: par <= par ^ data_s2;
                    default: ;
                endcase
            end
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver top: E0/F0 prefix decode, key events and held
// direction/start levels for the game logic.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN       = 8,
    parameter int TIMEOUT_CYCLES = 15000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_up,
    output logic       key_down,
    output logic       key_center
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext_pend, brk_pend;

    ps2_frame_rx #(
        .FILT_LEN      (FILT_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    assign frame_err = rx_err;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_valid  <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_up     <= 1'b0;
            key_down   <= 1'b0;
            key_center <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (rx_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= rx_byte;
                    key_ext   <= ext_pend;
                    key_break <= brk_pend;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                    // A make sets the level, a break clears it; repeats and stray breaks are harmless.
                    if (ext_pend && rx_byte == SC_LEFT)   key_left   <= !brk_pend;
                    if (ext_pend && rx_byte == SC_RIGHT)  key_right  <= !brk_pend;
                    if (ext_pend && rx_byte == SC_UP)     key_up     <= !brk_pend;
                    if (ext_pend && rx_byte == SC_DOWN)   key_down   <= !brk_pend;
                    if (!ext_pend && rx_byte == SC_SPACE) key_center <= !brk_pend;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Receive end of the PS/2 keyboard link, device to host. Replaces raw push-button sampling as the player-input source for the Tetris game.
- Oversamples the PS/2 clock and data lines, deserialises 11-bit frames, checks them, and decodes the E0 (extended) and F0 (break) prefixes.
- Drives one-cycle key events plus held-level direction and start signals.
- The held levels feed block_gen and game_array exactly as BtnL/BtnR/BtnU/BtnD/BtnC do today. They are safe to sample on the slow game clock.

Parameters:
- FILT_LEN, 8: consecutive identical samples needed before the filtered PS/2 clock changes value.
- TIMEOUT_CYCLES, 15000: Clk cycles allowed between PS/2 clock falling edges while a frame is in progress (150 us at 100 MHz).

Ports:
- Clk, input, 1: system clock, 100 MHz (ClkPort).
- Reset_n, input, 1: asynchronous active-low reset.
- ps2_clk, input, 1: raw PS/2 clock from the keyboard, asynchronous.
- ps2_data, input, 1: raw PS/2 data, asynchronous.
- key_code, output, 8: last decoded scan code, excluding prefix bytes.
- key_ext, output, 1: key_code was preceded by E0.
- key_break, output, 1: key_code was preceded by F0, i.e. a release.
- key_valid, output, 1: one-cycle pulse; key_code, key_ext and key_break are updated in this cycle.
- frame_err, output, 1: one-cycle pulse on a bad start bit, parity, stop bit, or timeout.
- key_left, output, 1: held level for E0 6B.
- key_right, output, 1: held level for E0 74.
- key_up, output, 1: held level for E0 75.
- key_down, output, 1: held level for E0 72.
- key_center, output, 1: held level for Space (29, no E0).

Behaviour:
- Reset: every output and all internal state go to 0 while Reset_n = 0, asynchronously. Takes effect mid-frame too; the partial frame is discarded.
- Input path: two-flop synchroniser on ps2_clk and ps2_data.
- Filtered clock: changes value only after FILT_LEN consecutive equal synchronised samples. A falling edge of the filtered clock is the bit strobe.
- On each strobe, sample the synchronised ps2_data.
- Frame FSM:
  - IDLE: a strobe with data = 0 goes to DATA. A strobe with data = 1 is ignored and the FSM stays in IDLE.
  - DATA: shifts 8 bits, LSB first, then goes to PARITY.
  - PARITY: checks odd parity over the 8 data bits plus the parity bit, then goes to STOP.
  - STOP: data must be 1. If it is and parity passed, the byte is delivered. In all cases the FSM returns to IDLE.
- Errors:
  - A parity failure or stop bit = 0 pulses frame_err for one cycle; no byte is delivered.
  - Timeout counter: cleared on every strobe; counts only while the FSM is not in IDLE. At TIMEOUT_CYCLES it pulses frame_err and the FSM returns to IDLE.
  - Any frame_err also clears the E0/F0 prefix flags.
- Prefix decode of delivered bytes:
  - E0 sets ext_pend; F0 sets brk_pend. Neither produces key_valid.
  - Any other byte pulses key_valid with key_code = byte, key_ext = ext_pend, key_break = brk_pend, then clears both flags.
  - E0 followed by F0 is legal and leaves both flags set.
- Latency: key_valid rises exactly 1 Clk cycle after the STOP-state strobe cycle.
- Held levels: set by the matching make event and cleared by the matching break event.
  - Typematic repeats re-pulse key_valid; the level stays 1.
  - A break for a key that is not held is a no-op.
  - Only one key_valid can occur per cycle, so make and break never collide.
- key_code, key_ext and key_break hold their values until the next key_valid.
- Host-to-device transmission is not supported; ps2_clk and ps2_data are never driven.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants: SC_EXT = E0, SC_BRK = F0, SC_LEFT = 6B, SC_RIGHT = 74, SC_UP = 75, SC_DOWN = 72, SC_SPACE = 29;
  - the frame FSM state encoding: IDLE, DATA, PARITY, STOP.
- Sub-module ps2_frame_rx contains the synchroniser, glitch filter, frame FSM, timeout counter and bit counter. It outputs byte[7:0], byte_valid and frame_err.
- ps2_key_rx instantiates ps2_frame_rx and adds the prefix decoder and the held-level key map.

Test Plan:
- Frame for 1C: start 0, data LSB first, parity 0, stop 1, 50 us bit period -> one key_valid, key_code = 1C, key_ext = 0, key_break = 0, no frame_err.
- Bytes E0, 6B, then E0, F0, 6B -> key_left = 1 after the first key_valid (key_ext = 1); key_left = 0 after the second (key_break = 1, key_ext = 1); exactly 2 key_valid pulses.
- Byte 29 with inverted parity bit -> one frame_err pulse, no key_valid, key_center stays 0. A following correct 29 -> key_center = 1.
- Start bit plus 5 data bits, then idle -> frame_err exactly TIMEOUT_CYCLES after the last strobe. A following valid F0, 29 -> key_break = 1 and key_center stays 0.
- 3-cycle low glitch on ps2_clk during IDLE and mid-frame, FILT_LEN = 8 -> no extra bit shifted, frame 1C still decodes correctly.
- Reset_n pulled low mid-frame while key_left is held -> all outputs 0 immediately, without waiting for a clock edge. After release, the next frame 75 with E0 prefix sets key_up = 1 cleanly.
